// File: rtl/cpu_trace_buffer.sv
// Trace capture FIFO: logs the CPU {addr, result} pair each enabled cycle and
// drains it over a first-word-fall-through valid/ready port with drop accounting.
module cpu_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter bit FILTER_DUP = 1'b1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          clear,
  input  logic          cap_en,
  input  logic [31:0]   addr,
  input  logic [31:0]   result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_result,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  // state     | meaning
  // ST_EMPTY  | no entries held, head invalid
  // ST_PART   | 1..DEPTH-1 entries held
  // ST_FULL   | DEPTH entries held, a push needs a same-edge pop
  typedef enum logic [1:0] {ST_EMPTY, ST_PART, ST_FULL} occ_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  occ_e          state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          last_vld_q, last_vld_d;
  logic [31:0]   last_addr_q, last_addr_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;

  logic want, pop, push, drop;

  always_comb begin
    want = cap_en & (!FILTER_DUP | !last_vld_q | (addr != last_addr_q));
    pop  = out_valid & out_ready;
    push = want & (!full | pop);
    drop = want & full & !pop;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    last_vld_d  = last_vld_q;
    last_addr_d = last_addr_q;
    if (clear) begin
      state_d     = ST_EMPTY;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      drop_cnt_d  = '0;
      last_vld_d  = 1'b0;
      last_addr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        last_addr_d = addr;
        last_vld_d  = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
      // Dropped samples leave last_addr alone so a repeat after draining is still logged.
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
      end
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_PART;
        ST_PART: begin
          if (push && !pop && count_q == FULL_CNT - ONE_CNT) state_d = ST_FULL;
          else if (pop && !push && count_q == ONE_CNT)      state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop && !push) state_d = ST_PART;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      last_vld_q  <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      last_vld_q  <= last_vld_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Storage is not reset; the head is gated by out_valid instead.
  always_ff @(posedge Clock) begin
    if (push && !clear) mem_q[wr_ptr_q] <= {addr, result};
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = (state_q != ST_EMPTY);
    full       = (state_q == ST_FULL);
    out_addr   = out_valid ? head[63:32] : '0;
    out_result = out_valid ? head[31:0]  : '0;
    count      = count_q;
    overflow   = overflow_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_cpu_trace_buffer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        clear, cap_en, out_ready;
  logic [31:0] addr, result;

  logic        out_valid, full, overflow;
  logic [31:0] out_addr, out_result;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  logic        out_valid0, full0, overflow0;
  logic [31:0] out_addr0, out_result0;
  logic [4:0]  count0;
  logic [15:0] drop_cnt0;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  cpu_trace_buffer #(.DEPTH(16), .AW(4), .FILTER_DUP(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .clear(clear), .cap_en(cap_en),
    .addr(addr), .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_result(out_result), .count(count), .full(full),
    .overflow(overflow), .drop_cnt(drop_cnt));

  cpu_trace_buffer #(.DEPTH(16), .AW(4), .FILTER_DUP(1'b0)) dut0 (
    .Clock(Clock), .Reset(Reset), .clear(clear), .cap_en(cap_en),
    .addr(addr), .result(result), .out_valid(out_valid0), .out_ready(out_ready),
    .out_addr(out_addr0), .out_result(out_result0), .count(count0), .full(full0),
    .overflow(overflow0), .drop_cnt(drop_cnt0));

  typedef struct {
    logic        clr;
    logic        cap;
    logic [31:0] a;
    logic [31:0] r;
    logic        rdy;
    int          e_cnt;
    logic        e_vld;
    logic [31:0] e_addr;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs[12];

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] m_last;
  logic        m_lvld;
  logic        m_ovf;
  int          m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_step();
    logic w, f, v, p, ps;
    w  = cap_en && (!m_lvld || addr != m_last);
    f  = (mq.size() == 16);
    v  = (mq.size() != 0);
    p  = v && out_ready;
    ps = w && (!f || p);
    if (clear) begin
      mq.delete();
      m_last = '0; m_lvld = 1'b0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      if (p) void'(mq.pop_front());
      if (ps) begin
        mq.push_back({addr, result});
        m_last = addr; m_lvld = 1'b1;
      end
      if (w && f && !p) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic model_check();
    chk("rnd_count", 64'(count), 64'(mq.size()));
    chk("rnd_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("rnd_full", 64'(full), 64'(mq.size() == 16));
    chk("rnd_overflow", 64'(overflow), 64'(m_ovf));
    chk("rnd_drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (mq.size() != 0) chk("rnd_head", {out_addr, out_result}, mq[0]);
    else                chk("rnd_head_zero", {out_addr, out_result}, 64'h0);
  endtask

  initial begin
    logic [63:0] got[$];
    int          budget;

    vecs[0]  = '{1'b1, 1'b0, 32'h000, 32'h00, 1'b0, 0, 1'b0, 32'h000, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h100, 32'hA0, 1'b0, 1, 1'b1, 32'h100, 32'hA0};
    vecs[2]  = '{1'b0, 1'b1, 32'h100, 32'hA1, 1'b0, 1, 1'b1, 32'h100, 32'hA0};
    vecs[3]  = '{1'b0, 1'b1, 32'h104, 32'hA2, 1'b0, 2, 1'b1, 32'h100, 32'hA0};
    vecs[4]  = '{1'b0, 1'b0, 32'h108, 32'hA3, 1'b1, 1, 1'b1, 32'h104, 32'hA2};
    vecs[5]  = '{1'b0, 1'b1, 32'h104, 32'hA4, 1'b1, 0, 1'b0, 32'h000, 32'h00};
    vecs[6]  = '{1'b0, 1'b1, 32'h104, 32'hA5, 1'b1, 0, 1'b0, 32'h000, 32'h00};
    vecs[7]  = '{1'b0, 1'b1, 32'h108, 32'hA6, 1'b1, 1, 1'b1, 32'h108, 32'hA6};
    vecs[8]  = '{1'b1, 1'b1, 32'h10C, 32'hA7, 1'b1, 0, 1'b0, 32'h000, 32'h00};
    vecs[9]  = '{1'b0, 1'b1, 32'h108, 32'hA8, 1'b0, 1, 1'b1, 32'h108, 32'hA8};
    vecs[10] = '{1'b0, 1'b1, 32'h000, 32'hA9, 1'b1, 1, 1'b1, 32'h000, 32'hA9};
    vecs[11] = '{1'b0, 1'b1, 32'h000, 32'hAA, 1'b1, 0, 1'b0, 32'h000, 32'h00};

    // T1: reset held with capture enabled
    Reset = 1'b0; clear = 1'b0; cap_en = 1'b1; out_ready = 1'b0;
    addr = 32'h40; result = 32'h41;
    #1;
    tick(); tick();
    chk("t1_valid", 64'(out_valid), 64'h0);
    chk("t1_count", 64'(count), 64'h0);
    chk("t1_overflow", 64'(overflow), 64'h0);
    chk("t1_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("t1_head", {out_addr, out_result}, 64'h0);
    cap_en = 1'b0;
    Reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      clear = vecs[i].clr; cap_en = vecs[i].cap; addr = vecs[i].a;
      result = vecs[i].r; out_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
      chk($sformatf("vec%0d_head", i), {out_addr, out_result}, {vecs[i].e_addr, vecs[i].e_res});
    end

    // T2: fill then drain in order
    clear = 1'b1; cap_en = 1'b0; out_ready = 1'b0; tick(); clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cap_en = 1'b1; addr = 32'(4*i); result = 32'(4*i + 1); tick();
    end
    cap_en = 1'b0;
    chk("t2_full", 64'(full), 64'h1);
    chk("t2_count", 64'(count), 64'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_drain%0d", i), {out_valid, out_addr, out_result},
          {1'b1, 32'(4*i), 32'(4*i + 1)});
      tick();
    end
    chk("t2_empty", 64'(out_valid), 64'h0);
    out_ready = 1'b0;

    // T3: overflow, then clear
    for (int i = 0; i < 16; i++) begin
      cap_en = 1'b1; addr = 32'(4*i); result = 32'(4*i + 1); tick();
    end
    for (int i = 0; i < 3; i++) begin
      addr = 32'h200 + 32'(4*i); result = 32'h5; tick();
    end
    cap_en = 1'b0;
    chk("t3_overflow", 64'(overflow), 64'h1);
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("t3_head", {out_addr, out_result}, {32'h0, 32'h1});
    chk("t3_count", 64'(count), 64'd16);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t3_clr_count", 64'(count), 64'h0);
    chk("t3_clr_overflow", 64'(overflow), 64'h0);
    chk("t3_clr_drop", 64'(drop_cnt), 64'h0);

    // T4/T5: duplicate filter on and off
    for (int i = 0; i < 5; i++) begin
      cap_en = 1'b1; addr = 32'h10; result = 32'(i * 7 + 3); tick();
    end
    cap_en = 1'b0;
    chk("t4_dup_on_count", 64'(count), 64'd1);
    chk("t5_dup_off_count", 64'(count0), 64'd5);

    // T6: full with simultaneous push and pop
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cap_en = 1'b1; addr = 32'(4*i); result = 32'(4*i + 1); tick();
    end
    addr = 32'h100; result = 32'h77; out_ready = 1'b1; tick();
    cap_en = 1'b0; out_ready = 1'b0;
    chk("t6_count", 64'(count), 64'd16);
    chk("t6_drop", 64'(drop_cnt), 64'h0);
    chk("t6_overflow", 64'(overflow), 64'h0);
    chk("t6_head", {out_addr, out_result}, {32'h4, 32'h5});

    // T7: 40 entries through with wrap
    clear = 1'b1; tick(); clear = 1'b0;
    got.delete();
    for (int k = 0; k < 40; k++) begin
      cap_en = 1'b1; addr = 32'h1000 + 32'(4*k); result = 32'h9000 + 32'(k);
      out_ready = (k % 3) != 0;
      if (out_valid && out_ready) got.push_back({out_addr, out_result});
      tick();
    end
    cap_en = 1'b0; out_ready = 1'b1;
    budget = 100;
    while (out_valid && budget > 0) begin
      got.push_back({out_addr, out_result});
      tick();
      budget--;
    end
    chk("t7_drain_done", 64'(out_valid), 64'h0);
    chk("t7_total", 64'(got.size()), 64'd40);
    for (int k = 0; k < 40 && k < got.size(); k++)
      chk($sformatf("t7_entry%0d", k), got[k], {32'h1000 + 32'(4*k), 32'h9000 + 32'(k)});

    // T8: async reset mid-drain
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cap_en = 1'b1; addr = 32'h300 + 32'(4*i); result = 32'(i); tick();
    end
    cap_en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    #2 Reset = 1'b0;
    #1;
    chk("t8_valid", 64'(out_valid), 64'h0);
    chk("t8_count", 64'(count), 64'h0);
    chk("t8_head", {out_addr, out_result}, 64'h0);
    chk("t8_full", 64'(full), 64'h0);
    tick();
    Reset = 1'b1; out_ready = 1'b0;
    tick();
    chk("t8_after_count", 64'(count), 64'h0);

    // Randomized traffic against the model
    clear = 1'b1; tick(); clear = 1'b0;
    mq.delete(); m_last = '0; m_lvld = 1'b0; m_ovf = 1'b0; m_drop = 0;
    for (int n = 0; n < 2000; n++) begin
      clear     = ($urandom_range(0, 199) == 0);
      cap_en    = ($urandom_range(0, 9) < 7);
      addr      = 32'($urandom_range(0, 7)) << 2;
      result    = $urandom;
      out_ready = (n < 1000) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      model_step();
      tick();
      model_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
